// File: rtl/wb_write_queue_pkg.sv
// Shared definitions for the register-bank write-back path: widths, the queue
// entry layout and the address-to-RegWrite decoder.
package misp_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Bundle between the pipeline (master side) and the write-back queue (slave
// side): write requests, drain bus to the register bank, forwarding lookup.
interface wb_write_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import misp_pkg::*;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    hold;
  logic [DATA_W-1:0]       reg_d;
  logic [NREG-1:0]         reg_sel;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    fwd_hit;
  logic [DATA_W-1:0]       fwd_data;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;

  modport master (
    output wr_valid, wr_addr, wr_data, hold, rd_addr,
    input  wr_ready, reg_d, reg_sel, fwd_hit, fwd_data, count, full, empty
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, hold, rd_addr,
    output wr_ready, reg_d, reg_sel, fwd_hit, fwd_data, count, full, empty
  );

endinterface

// File: rtl/wb_write_queue_fwd_match.sv
// Forwarding lookup over the pending write entries; the youngest matching
// entry supplies the data.
module wb_fwd_match
  import misp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t                   entries [DEPTH],
  input  logic [DEPTH-1:0]            valid,
  input  logic [$clog2(DEPTH)-1:0]    tail,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk slots from tail (oldest) towards tail-1 (youngest); a later match
  // overrides an earlier one, so the youngest hit is what remains.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned age = 0; age < DEPTH; age++) begin
      idx = tail + PTR_W'(age);
      if (valid[idx] && (entries[idx].addr == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue in front of the register bank: buffers register writes and
// drains one per clock as a data bus plus one-hot RegWrite vector.
module wb_write_queue
  import misp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            CLK,
  input  logic            reset_n,
  wb_write_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t          mem_q   [DEPTH];
  wb_entry_t          mem_d   [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   head_q,  head_d;
  logic [PTR_W-1:0]   tail_q,  tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic      full, empty, push, pop;
  wb_entry_t head_e;

  always_comb begin
    full   = (count_q == CNT_W'(DEPTH));
    empty  = (count_q == '0);
    push   = bus.wr_valid && !full;
    pop    = !empty && !bus.hold;
    head_e = mem_q[head_q];
  end

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q]   = '{addr: bus.wr_addr, data: bus.wr_data};
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset too, so reg_d reads zero while idle after reset.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // RegWrite only while a pop is committed for this cycle; reset kills it at once.
  always_comb begin
    bus.reg_sel = pop ? addr_onehot(head_e.addr) : '0;
    bus.reg_d   = head_e.data;
  end

  assign bus.wr_ready = !full;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;

  wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries  (mem_q),
    .valid    (valid_q),
    .tail     (tail_q),
    .rd_addr  (bus.rd_addr),
    .fwd_hit  (bus.fwd_hit),
    .fwd_data (bus.fwd_data)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: scoreboard of accepted writes checked
// against every drain, plus an emulated register bank captured on negedge.
module tb_wb_write_queue;
  import misp_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;

  wb_write_queue_if #(.DEPTH(DEPTH)) bus ();

  wb_write_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  wb_entry_t       sb [$];
  logic [DATA_W-1:0] regs [NREG];
  int unsigned     total  = 0;
  int unsigned     passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: check the drain at negedge against the scoreboard, update the
  // register model, then record the accept decided by the model occupancy.
  task automatic cycle();
    wb_entry_t   e;
    logic        drain_exp;
    logic        acc;
    int unsigned occ;
    @(negedge CLK);
    occ       = sb.size();
    drain_exp = !bus.hold && (occ != 0);
    chk("wr_ready", 32'(bus.wr_ready), 32'(occ < DEPTH));
    chk("drain_active", 32'(bus.reg_sel != '0), 32'(drain_exp));
    if (drain_exp && (bus.reg_sel != '0)) begin
      e = sb.pop_front();
      chk("drain_sel", 32'(bus.reg_sel), 32'(addr_onehot(e.addr)));
      chk("drain_data", 32'(bus.reg_d), 32'(e.data));
    end
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bus.reg_sel[i]) regs[i] = bus.reg_d;
    end
    acc = bus.wr_valid && (occ < DEPTH);
    @(posedge CLK);
    if (acc) sb.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    #1;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    cycle();
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain_all();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_bound", sb.size(), 0);
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_count", 32'(bus.count), 0);
  endtask

  initial begin
    for (int unsigned i = 0; i < NREG; i++) regs[i] = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.hold     = 1'b0;
    bus.rd_addr  = '0;

    // Reset state
    @(posedge CLK);
    #1;
    chk("rst_empty",    32'(bus.empty), 1);
    chk("rst_full",     32'(bus.full), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    chk("rst_count",    32'(bus.count), 0);
    chk("rst_reg_sel",  32'(bus.reg_sel), 0);
    chk("rst_fwd_hit",  32'(bus.fwd_hit), 0);
    chk("rst_fwd_data", 32'(bus.fwd_data), 0);
    chk("rst_reg_d",    32'(bus.reg_d), 0);
    reset_n = 1'b1;
    cycle();

    // Single write into empty queue: visible at head in the cycle after accept
    push_one(4'd3, 16'hBEEF);
    chk("t1_reg_sel", 32'(bus.reg_sel), 32'h0008);
    chk("t1_reg_d",   32'(bus.reg_d), 32'hBEEF);
    chk("t1_count",   32'(bus.count), 1);
    cycle();
    chk("t1_empty", 32'(bus.empty), 1);
    chk("t1_count_after", 32'(bus.count), 0);
    chk("t1_reg3", 32'(regs[3]), 32'hBEEF);

    // Fill under hold
    bus.hold = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      push_one(ADDR_W'(i), DATA_W'(i * 16'h0011));
      chk("t2_reg_sel_hold", 32'(bus.reg_sel), 0);
    end
    chk("t2_full",     32'(bus.full), 1);
    chk("t2_wr_ready", 32'(bus.wr_ready), 0);
    chk("t2_count",    32'(bus.count), 4);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd6;
    bus.wr_data  = 16'h0055;
    cycle();
    chk("t2_fifth_rejected", 32'(bus.count), 4);

    // Release hold while full: no bypass on the first pop edge
    bus.hold = 1'b0;
    cycle();
    chk("t3_no_bypass_count", 32'(bus.count), 3);
    chk("t3_ready_after_pop", 32'(bus.wr_ready), 1);
    cycle();
    chk("t3_fifth_accepted", 32'(bus.count), 3);
    bus.wr_valid = 1'b0;
    drain_all();
    chk("t3_reg6", 32'(regs[6]), 32'h0055);

    // Forwarding: youngest of two same-address writes wins
    bus.hold = 1'b1;
    push_one(4'd5, 16'h1111);
    push_one(4'd5, 16'h2222);
    bus.rd_addr = 4'd5;
    #1;
    chk("t4_fwd_hit",  32'(bus.fwd_hit), 1);
    chk("t4_fwd_data", 32'(bus.fwd_data), 32'h2222);
    bus.rd_addr = 4'd7;
    #1;
    chk("t4_miss_hit",  32'(bus.fwd_hit), 0);
    chk("t4_miss_data", 32'(bus.fwd_data), 0);
    bus.rd_addr = 4'd5;
    bus.hold = 1'b0;
    drain_all();
    chk("t4_fwd_after_drain", 32'(bus.fwd_hit), 0);
    chk("t4_reg5", 32'(regs[5]), 32'h2222);

    // Steady stream at count 2 across pointer wrap
    bus.hold = 1'b1;
    push_one(4'd8, 16'h8888);
    push_one(4'd9, 16'h9999);
    bus.hold = 1'b0;
    bus.wr_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      bus.wr_addr = ADDR_W'((10 + i) % 16);
      bus.wr_data = DATA_W'(16'hA000 + i);
      cycle();
      chk("t5_count_steady", 32'(bus.count), 2);
    end
    bus.wr_valid = 1'b0;
    drain_all();
    chk("t5_reg1", 32'(regs[1]), 32'hA007);

    // Asynchronous reset with three entries pending
    bus.hold = 1'b1;
    push_one(4'd1, 16'hAAA1);
    push_one(4'd2, 16'hAAA2);
    push_one(4'd3, 16'hAAA3);
    bus.hold = 1'b0;
    #1;
    chk("t6_pre_reset_sel", 32'(bus.reg_sel), 32'h0002);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_reg_sel", 32'(bus.reg_sel), 0);
    chk("t6_rst_count",   32'(bus.count), 0);
    chk("t6_rst_empty",   32'(bus.empty), 1);
    @(negedge CLK);
    chk("t6_negedge_reg_sel", 32'(bus.reg_sel), 0);
    sb.delete();
    @(posedge CLK);
    #1;
    reset_n = 1'b1;
    cycle();
    chk("t6_post_count", 32'(bus.count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
